// File: rtl/pipemem_stage.sv
// pipemem_stage: MEM stage with byte/half/word data memory and a wait-state FSM.
// Each access takes WAIT+1 cycles; mstall freezes upstream until the completion cycle.
module pipemem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int WAIT  = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [1:0]  msize,
    input  logic        msigned,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        mmisalign
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH];
    logic        req, mis, done, stall, we, ld;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wdata, rd, ext;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic        unused_hi;

    assign req       = mwmem | mm2reg;
    assign idx       = malu[AW+1:2];
    assign unused_hi = ^malu[31:AW+2];
    assign mis       = (msize == 2'b01 && malu[0]) || (msize[1] && malu[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            if (req) begin
                if (WAIT == 0) begin
                    done = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = WAIT_M1;
                end
            end
        end else if (cnt_q != 4'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
        end else begin
            done    = 1'b1;
            state_d = IDLE;
        end
    end

    // Store wins when both requests are raised; misaligned accesses have no effect.
    assign we    = done && mwmem && !mis;
    assign ld    = resetn && done && mm2reg && !mwmem && !mis;
    assign be    = msize == 2'b00 ? 4'b0001 << malu[1:0] :
                   msize == 2'b01 ? (malu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = msize == 2'b00 ? {4{mb[7:0]}} : msize == 2'b01 ? {2{mb[15:0]}} : mb;

    assign rd   = mem_q[idx];
    assign bsel = rd[{malu[1:0], 3'b000} +: 8];
    assign hsel = malu[1] ? rd[31:16] : rd[15:0];
    assign ext  = msize == 2'b00 ? {{24{msigned & bsel[7]}}, bsel} :
                  msize == 2'b01 ? {{16{msigned & hsel[15]}}, hsel} : rd;

    assign mmo       = ld ? ext : 32'd0;
    assign mstall    = resetn & stall;
    assign mmisalign = resetn & req & mis;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_pipemem_stage.sv
// tb_pipemem_stage: directed checks of a WAIT=2 and a WAIT=0 instance sharing stimulus.
module tb_pipemem_stage;
    logic        clk = 1'b0;
    logic        resetn, mwmem, mm2reg, msigned;
    logic [1:0]  msize;
    logic [31:0] malu, mb;
    logic [31:0] mmo0, mmo2;
    logic        mstall0, mstall2, mis0, mis2;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pipemem_stage #(.DEPTH(256), .AW(8), .WAIT(0)) u0 (
        .clock(clk), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg), .msize(msize),
        .msigned(msigned), .malu(malu), .mb(mb), .mmo(mmo0), .mstall(mstall0), .mmisalign(mis0));
    pipemem_stage #(.DEPTH(256), .AW(8), .WAIT(2)) u2 (
        .clock(clk), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg), .msize(msize),
        .msigned(msigned), .malu(malu), .mb(mb), .mmo(mmo2), .mstall(mstall2), .mmisalign(mis2));

    // Drives one access and waits (bounded) for its completion cycle on the chosen instance.
    task automatic access(input int which, input logic we, input logic re, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] data, output logic mis);
        logic fin = 1'b0;
        mwmem = we; mm2reg = re; msize = sz; msigned = sg; malu = a; mb = d;
        stalls = 0; data = 32'hx; mis = 1'bx;
        while (!fin && stalls < 20) begin
            @(negedge clk);
            if ((which == 0 ? mstall0 : mstall2) === 1'b0) begin
                data = which == 0 ? mmo0 : mmo2;
                mis  = which == 0 ? mis0 : mis2;
                fin  = 1'b1;
            end else stalls++;
        end
        @(posedge clk); #1;
        mwmem = 1'b0; mm2reg = 1'b0;
    endtask

    task automatic test_reset;
        int st; logic [31:0] d; logic mi;
        mm2reg = 1'b1; msize = 2'b10; malu = 32'h10;
        #12;
        n_cmp++; if ({mstall0, mstall2} !== 2'b00) begin n_bad++; $display("FAIL rst_stall got=%b exp=00", {mstall0, mstall2}); end
        n_cmp++; if (mmo0 !== 32'd0 || mmo2 !== 32'd0) begin n_bad++; $display("FAIL rst_mmo got=%h/%h exp=0", mmo0, mmo2); end
        n_cmp++; if ({mis0, mis2} !== 2'b00) begin n_bad++; $display("FAIL rst_mis got=%b exp=00", {mis0, mis2}); end
        mm2reg = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        access(2, 0, 1, 2'b10, 0, 32'h10, 0, st, d, mi);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL rst_load_stalls got=%0d exp=2", st); end
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_load_mmo got=%h exp=00000000", d); end
    endtask

    task automatic test_word;
        int st; logic [31:0] d; logic mi;
        access(2, 1, 0, 2'b10, 0, 32'h20, 32'hDEADBEEF, st, d, mi);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL st_stalls got=%0d exp=2", st); end
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL st_mmo got=%h exp=00000000", d); end
        access(2, 0, 1, 2'b10, 0, 32'h20, 0, st, d, mi);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL ld_stalls got=%0d exp=2", st); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word got=%h exp=deadbeef", d); end
    endtask

    task automatic test_wrap_reset;
        int st; logic [31:0] d; logic mi;
        access(2, 1, 0, 2'b10, 0, 32'h400, 32'hA5A5A5A5, st, d, mi);
        access(2, 0, 1, 2'b10, 0, 32'h0, 0, st, d, mi);
        n_cmp++; if (d !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL wrap got=%h exp=a5a5a5a5", d); end
        mwmem = 1'b1; msize = 2'b10; malu = 32'h8; mb = 32'hFFFFFFFF;
        @(posedge clk); #1;
        resetn = 1'b0; #2;
        n_cmp++; if (mstall2 !== 1'b0) begin n_bad++; $display("FAIL rst_busy_stall got=%b exp=0", mstall2); end
        mwmem = 1'b0; resetn = 1'b1;
        @(posedge clk); #1;
        access(2, 0, 1, 2'b10, 0, 32'h8, 0, st, d, mi);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_busy_mem got=%h exp=00000000", d); end
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL rst_busy_idle got=%0d exp=2", st); end
        access(2, 0, 1, 2'b10, 0, 32'h20, 0, st, d, mi);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_clears got=%h exp=00000000", d); end
    endtask

    task automatic test_subword;
        int st; logic [31:0] d; logic mi;
        access(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, st, d, mi);
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL w0_stalls got=%0d exp=0", st); end
        access(0, 1, 0, 2'b00, 0, 32'h41, 32'h80, st, d, mi);
        access(0, 0, 1, 2'b00, 1, 32'h41, 0, st, d, mi);
        n_cmp++; if (d !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb got=%h exp=ffffff80", d); end
        access(0, 0, 1, 2'b00, 0, 32'h41, 0, st, d, mi);
        n_cmp++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL lbu got=%h exp=00000080", d); end
        access(0, 0, 1, 2'b01, 1, 32'h40, 0, st, d, mi);
        n_cmp++; if (d !== 32'hFFFF8000) begin n_bad++; $display("FAIL lh got=%h exp=ffff8000", d); end
        access(0, 0, 1, 2'b10, 1, 32'h40, 0, st, d, mi);
        n_cmp++; if (d !== 32'h00008000) begin n_bad++; $display("FAIL lw got=%h exp=00008000", d); end
        access(0, 1, 0, 2'b01, 0, 32'h42, 32'h1234, st, d, mi);
        access(0, 0, 1, 2'b10, 0, 32'h40, 0, st, d, mi);
        n_cmp++; if (d !== 32'h12348000) begin n_bad++; $display("FAIL sh_hi got=%h exp=12348000", d); end
        access(0, 0, 1, 2'b01, 0, 32'h42, 0, st, d, mi);
        n_cmp++; if (d !== 32'h00001234) begin n_bad++; $display("FAIL lhu_hi got=%h exp=00001234", d); end
    endtask

    task automatic test_misalign;
        int st; logic [31:0] d; logic mi;
        access(0, 1, 0, 2'b10, 0, 32'h42, 32'h12345678, st, d, mi);
        n_cmp++; if (mi !== 1'b1) begin n_bad++; $display("FAIL mis_store got=%b exp=1", mi); end
        access(0, 0, 1, 2'b10, 0, 32'h40, 0, st, d, mi);
        n_cmp++; if (d !== 32'h12348000) begin n_bad++; $display("FAIL mis_nowrite got=%h exp=12348000", d); end
        n_cmp++; if (mi !== 1'b0) begin n_bad++; $display("FAIL mis_aligned got=%b exp=0", mi); end
        access(0, 0, 1, 2'b01, 0, 32'h43, 0, st, d, mi);
        n_cmp++; if (mi !== 1'b1) begin n_bad++; $display("FAIL mis_half got=%b exp=1", mi); end
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL mis_half_mmo got=%h exp=00000000", d); end
    endtask

    task automatic test_both;
        int st; logic [31:0] d; logic mi;
        access(0, 1, 1, 2'b10, 0, 32'h50, 32'h11, st, d, mi);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL both_mmo got=%h exp=00000000", d); end
        access(0, 0, 1, 2'b10, 0, 32'h50, 0, st, d, mi);
        n_cmp++; if (d !== 32'h00000011) begin n_bad++; $display("FAIL both_store got=%h exp=00000011", d); end
    endtask

    initial begin
        resetn = 1'b0; mwmem = 1'b0; mm2reg = 1'b0; msize = 2'b00; msigned = 1'b0;
        malu = 32'd0; mb = 32'd0;
        test_reset;
        test_word;
        test_wrap_reset;
        test_subword;
        test_misalign;
        test_both;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
